elk_mem_arbiter: RTL

- Owns the single-port ROM BRAM (7×16 KB) and sideways-RAM BRAM (8×16 KB) in the Electron top level.
- Shares both BRAMs between two requesters: HPS ioctl ROM download and the Electron core external bus.
- Sequences core reset around downloads, decodes the core's 19-bit external address into BRAM bank selects, and converts the core's level write strobe into single-cycle BRAM writes.

---
 rtl/elk_mem_arbiter_if.sv | 37 +++
 rtl/elk_mem_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/elk_mem_arbiter_if.sv
// Signal bundle around the Electron ROM/RAM BRAM arbiter: HPS ioctl download,
// core external bus and the two BRAM ports. slave is the arbiter side.
interface elk_mem_arbiter_if;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [18:0] core_a;
    logic        core_we_n;
    logic [7:0]  core_din;
    logic [7:0]  core_dout;
    logic        core_reset;
    logic [16:0] rom_addr;
    logic        rom_we;
    logic [16:0] ram_addr;
    logic        ram_we;
    logic [7:0]  mem_din;
    logic [7:0]  rom_q;
    logic [7:0]  ram_q;
    logic [16:0] load_bytes;
    logic        load_err;

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        input  core_a, core_we_n, core_din, rom_q, ram_q,
        output core_dout, core_reset, rom_addr, rom_we, ram_addr, ram_we,
        output mem_din, load_bytes, load_err
    );

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        output core_a, core_we_n, core_din, rom_q, ram_q,
        input  core_dout, core_reset, rom_addr, rom_we, ram_addr, ram_we,
        input  mem_din, load_bytes, load_err
    );
endinterface

// File: rtl/elk_mem_arbiter.sv
// Shares the Electron ROM and sideways-RAM BRAMs between HPS ROM download and
// the core bus; holds the core in reset around downloads.
module elk_mem_arbiter #(
    parameter int ROM_INDEX   = 0,
    parameter int ROM_BYTES   = 114688,
    parameter int HOLD_CYCLES = 64
) (
    input  logic             clk_sys,
    input  logic             reset,
    elk_mem_arbiter_if.slave bus
);
    localparam logic [24:0] ROM_LIMIT = 25'(ROM_BYTES);
    localparam logic [7:0]  HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0]  IDX       = 8'(ROM_INDEX);

    typedef enum logic [1:0] {RUN, LOAD, HOLD} state_t;
    state_t state, state_next;

    logic        dl_start;
    logic        ld_accept;
    logic        ld_reject;
    logic        core_wr;
    logic        we_n_q;
    logic [7:0]  hold_cnt;
    logic        rom_we_q;
    logic        ram_we_q;
    logic [16:0] wr_addr;
    logic [7:0]  din_q;
    logic [16:0] load_bytes_q;
    logic        load_err_q;
    logic        core_reset_q;
    logic        rom_hit;
    logic        ram_hit;
    logic        rom_sel;
    logic        ram_sel;
    logic [2:0]  rom_bank;
    logic [7:0]  dout_q;

    assign dl_start  = bus.ioctl_download && (bus.ioctl_index == IDX);
    assign ld_accept = (state == LOAD) && bus.ioctl_wr && (bus.ioctl_addr < ROM_LIMIT);
    assign ld_reject = (state == LOAD) && bus.ioctl_wr && (bus.ioctl_addr >= ROM_LIMIT);

    // A download start in the same cycle as a write edge wins; the write is lost.
    assign core_wr = (state == RUN) && !dl_start && we_n_q && !bus.core_we_n && ram_hit;

    always_ff @(posedge clk_sys) begin
        if (reset) state <= RUN;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:  if (dl_start) state_next = LOAD;
            LOAD: if (!bus.ioctl_download) state_next = HOLD;
            HOLD: begin
                if (dl_start)                    state_next = LOAD;
                else if (hold_cnt == HOLD_LAST)  state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    // ROM banks live in 16 KB windows of the low 256 KB; banks 1 and 2 are mirrored.
    always_comb begin
        rom_hit  = 1'b1;
        rom_bank = 3'd0;
        case (bus.core_a[18:14])
            5'b00100:           rom_bank = 3'd0;
            5'b01000, 5'b01001: rom_bank = 3'd1;
            5'b01010, 5'b01011: rom_bank = 3'd2;
            5'b01100:           rom_bank = 3'd3;
            5'b01101:           rom_bank = 3'd4;
            5'b01110:           rom_bank = 3'd5;
            5'b01111:           rom_bank = 3'd6;
            default:            rom_hit  = 1'b0;
        endcase
    end

    assign ram_hit = (bus.core_a[18:17] == 2'b10);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            we_n_q       <= 1'b1;
            hold_cnt     <= 8'd0;
            rom_we_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            wr_addr      <= 17'd0;
            din_q        <= 8'd0;
            load_bytes_q <= 17'd0;
            load_err_q   <= 1'b0;
            core_reset_q <= 1'b1;
            rom_sel      <= 1'b0;
            ram_sel      <= 1'b0;
            dout_q       <= 8'd0;
        end else begin
            we_n_q       <= bus.core_we_n;
            hold_cnt     <= (state == HOLD) ? hold_cnt + 8'd1 : 8'd0;
            rom_we_q     <= ld_accept;
            ram_we_q     <= core_wr;
            core_reset_q <= (state_next != RUN);
            rom_sel      <= rom_hit;
            ram_sel      <= ram_hit;
            dout_q       <= rom_sel ? bus.rom_q : (ram_sel ? bus.ram_q : 8'h00);

            if (ld_accept) begin
                wr_addr <= bus.ioctl_addr[16:0];
                din_q   <= bus.ioctl_dout;
            end else if (core_wr) begin
                wr_addr <= bus.core_a[16:0];
                din_q   <= bus.core_din;
            end

            if (state != LOAD && state_next == LOAD) begin
                load_bytes_q <= 17'd0;
                load_err_q   <= 1'b0;
            end else begin
                if (ld_accept && load_bytes_q != '1) load_bytes_q <= load_bytes_q + 17'd1;
                if (ld_reject) load_err_q <= 1'b1;
            end
        end
    end

    // Write cycles present the latched write address; otherwise the core address reads.
    assign bus.rom_addr   = rom_we_q ? wr_addr : {rom_bank, bus.core_a[13:0]};
    assign bus.ram_addr   = ram_we_q ? wr_addr : bus.core_a[16:0];
    assign bus.rom_we     = rom_we_q;
    assign bus.ram_we     = ram_we_q;
    assign bus.mem_din    = din_q;
    assign bus.core_dout  = dout_q;
    assign bus.core_reset = core_reset_q;
    assign bus.load_bytes = load_bytes_q;
    assign bus.load_err   = load_err_q;
endmodule
